// File: rtl/hdmi_video_pkg.sv
// hdmi_video_pkg: BT.709 limited-range coefficients, clamp bounds, pipeline latency and shared video types.
package hdmi_video_pkg;
    localparam int LATENCY = 4;
    // Rows are Y, Cb, Cr; columns are the R, G, B weights (x256).
    localparam logic signed [8:0] COEF [3][3] = '{
        '{ 9'sd47,   9'sd157,  9'sd16 },
        '{-9'sd26,  -9'sd86,   9'sd112},
        '{ 9'sd112, -9'sd102, -9'sd10 }
    };
    localparam logic signed [17:0] OFFS [3] = '{18'sd16, 18'sd128, 18'sd128};
    localparam logic [7:0] LO [3] = '{8'd16, 8'd16, 8'd16};
    localparam logic [7:0] HI [3] = '{8'd235, 8'd240, 8'd240};
    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } ycc_t;
    typedef enum logic {PH_EVEN, PH_ODD} phase_t;
    function automatic logic [7:0] sat8(input logic signed [17:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return v < $signed({10'd0, lo}) ? lo : v > $signed({10'd0, hi}) ? hi : v[7:0];
    endfunction
endpackage

// File: rtl/hdmi_csc422_if.sv
// hdmi_csc422_if: video bus into and out of the converter.
//   rgb_in/pix_in/de_in/hs_in/vs_in : source pixel and syncs
//   data_out/de_out/hs_out/vs_out   : 4:2:2 pixel {chroma, Y} and aligned syncs
interface hdmi_csc422_if;
    logic        rgb_in;
    logic [23:0] pix_in;
    logic        de_in;
    logic        hs_in;
    logic        vs_in;
    logic [15:0] data_out;
    logic        de_out;
    logic        hs_out;
    logic        vs_out;
    modport master (output rgb_in, pix_in, de_in, hs_in, vs_in, input data_out, de_out, hs_out, vs_out);
    modport slave (input rgb_in, pix_in, de_in, hs_in, vs_in, output data_out, de_out, hs_out, vs_out);
endinterface

// File: rtl/csc_rgb2ycbcr.sv
// csc_rgb2ycbcr: two-stage RGB -> YCbCr 4:4:4 matrix with optional clamp and a YCbCr bypass.
//   sys2_clk : pixel clock
//   mode_i   : 1 = convert pix_i as RGB, 0 = pass pix_i through as YCbCr
//   pix_i    : {R/Y, G/Cb, B/Cr}
//   ycc_o    : converted pixel, two cycles after pix_i
module csc_rgb2ycbcr
    import hdmi_video_pkg::*;
#(
    parameter bit CLAMP_EN = 1'b1
) (
    input  logic        sys2_clk,
    input  logic        mode_i,
    input  logic [23:0] pix_i,
    output ycc_t        ycc_o
);
    logic signed [17:0] prod_q [3][3];
    logic signed [17:0] acc [3];
    logic [7:0] res [3];
    ycc_t byp_q, ycc_d, ycc_q;
    logic mode_q;
    always_ff @(posedge sys2_clk) begin
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++)
                prod_q[k][j] <= COEF[k][j] * $signed({1'b0, pix_i[23-8*j -: 8]});
        byp_q <= ycc_t'(pix_i);
        mode_q <= mode_i;
        ycc_q <= ycc_d;
    end
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            acc[k] = ((prod_q[k][0] + prod_q[k][1] + prod_q[k][2] + 18'sd128) >>> 8) + OFFS[k];
            res[k] = CLAMP_EN ? sat8(acc[k], LO[k], HI[k]) : acc[k][7:0];
        end
        ycc_d = mode_q ? ycc_t'{res[0], res[1], res[2]} : byp_q;
    end
    assign ycc_o = ycc_q;
endmodule

// File: rtl/hdmi_csc422.sv
// hdmi_csc422: RGB/YCbCr 4:4:4 to YCbCr 4:2:2 converter with a fixed 4-cycle latency.
//   sys2_clk : pixel clock
//   sys2_rst : synchronous active-high reset
//   vid      : pixel/sync inputs and {chroma, Y} 4:2:2 output with aligned syncs
module hdmi_csc422
    import hdmi_video_pkg::*;
#(
    parameter bit         CLAMP_EN = 1'b1,
    parameter logic [7:0] BLANK_Y  = 8'h10,
    parameter logic [7:0] BLANK_C  = 8'h80
) (
    input  logic          sys2_clk,
    input  logic          sys2_rst,
    hdmi_csc422_if.slave  vid
);
    logic [2:0] sync_q [LATENCY];
    logic mode_q, vs_prev_q;
    ycc_t ycc2, s3_q;
    phase_t phase_q, phase_d;
    logic [7:0] cr_hold_q, cb_avg, cr_avg;
    logic [8:0] cb_sum, cr_sum;
    logic [15:0] data_q, data_d;
    logic de2, de3;
    csc_rgb2ycbcr #(.CLAMP_EN(CLAMP_EN)) u_csc (
        .sys2_clk (sys2_clk),
        .mode_i   (mode_q),
        .pix_i    (vid.pix_in),
        .ycc_o    (ycc2)
    );
    // Stage 3 holds the current pixel; the stage-2 result is its successor (lookahead).
    always_comb begin
        de2 = sync_q[1][0];
        de3 = sync_q[2][0];
        phase_d = (de3 && phase_q == PH_EVEN) ? PH_ODD : PH_EVEN;
        cb_sum = s3_q.cb + ycc2.cb + 9'd1;
        cr_sum = s3_q.cr + ycc2.cr + 9'd1;
        cb_avg = de2 ? cb_sum[8:1] : s3_q.cb;
        cr_avg = cr_sum[8:1];
        // The pair's averaged Cr is computed on the even pixel and held for the odd one.
        data_d = !de3 ? {BLANK_C, BLANK_Y} : phase_q == PH_EVEN ? {cb_avg, s3_q.y} : {cr_hold_q, s3_q.y};
    end
    always_ff @(posedge sys2_clk) begin
        if (sys2_rst) begin
            for (int i = 0; i < LATENCY; i++)
                sync_q[i] <= '0;
            mode_q <= 1'b1;
            vs_prev_q <= 1'b0;
            s3_q <= '0;
            phase_q <= PH_EVEN;
            cr_hold_q <= '0;
            data_q <= {BLANK_C, BLANK_Y};
        end else begin
            sync_q[0] <= {vid.vs_in, vid.hs_in, vid.de_in};
            for (int i = 1; i < LATENCY; i++)
                sync_q[i] <= sync_q[i-1];
            vs_prev_q <= vid.vs_in;
            if (vid.vs_in && !vs_prev_q)
                mode_q <= vid.rgb_in;
            s3_q <= ycc2;
            phase_q <= phase_d;
            cr_hold_q <= cr_avg;
            data_q <= data_d;
        end
    end
    assign vid.data_out = data_q;
    assign vid.de_out = sync_q[LATENCY-1][0];
    assign vid.hs_out = sync_q[LATENCY-1][1];
    assign vid.vs_out = sync_q[LATENCY-1][2];
endmodule

// File: tb/tb_hdmi_csc422.sv
// tb_hdmi_csc422: directed-vector bench for hdmi_csc422 with hand-computed expectations.
module tb_hdmi_csc422;
    logic sys2_clk;
    logic sys2_rst;
    int total = 0;
    int bad = 0;
    logic [18:0] hist [$];
    logic [2:0] pat [12] = '{3'b001, 3'b011, 3'b001, 3'b010, 3'b110, 3'b100,
                             3'b101, 3'b111, 3'b001, 3'b000, 3'b010, 3'b001};
    hdmi_csc422_if vid ();
    hdmi_csc422 dut (
        .sys2_clk (sys2_clk),
        .sys2_rst (sys2_rst),
        .vid      (vid)
    );
    initial sys2_clk = 1'b0;
    always #5 sys2_clk = ~sys2_clk;
    task automatic tick(input logic de, input logic hs, input logic vs, input logic rgb, input logic [23:0] pix);
        vid.de_in = de;
        vid.hs_in = hs;
        vid.vs_in = vs;
        vid.rgb_in = rgb;
        vid.pix_in = pix;
        @(posedge sys2_clk);
        #1;
        hist.push_back({vid.vs_out, vid.hs_out, vid.de_out, vid.data_out});
    endtask
    task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    initial begin
        sys2_rst = 1'b1;
        tick(1, 1, 1, 1, 24'hFFFFFF);
        tick(1, 1, 1, 1, 24'hFFFFFF);
        chk("reset", hist[1], {3'b000, 16'h8010});
        // White pixel, exact 4-cycle latency.
        sys2_rst = 1'b0;
        hist.delete();
        tick(1, 0, 0, 1, 24'hFFFFFF);
        repeat (5) tick(0, 0, 0, 1, 24'h000000);
        chk("white_early", hist[2], {3'b000, 16'h8010});
        chk("white", hist[3], {3'b001, 16'h80EB});
        chk("white_after", hist[4], {3'b000, 16'h8010});
        // Red line.
        hist.delete();
        repeat (4) tick(1, 0, 0, 1, 24'hFF0000);
        repeat (4) tick(0, 0, 0, 1, 24'h000000);
        chk("red_p0", hist[3], {3'b001, 16'h663F});
        chk("red_p1", hist[4], {3'b001, 16'hF03F});
        chk("red_p2", hist[5], {3'b001, 16'h663F});
        chk("red_p3", hist[6], {3'b001, 16'hF03F});
        chk("red_end", hist[7], {3'b000, 16'h8010});
        // Black, then blanking with garbage pixels.
        hist.delete();
        repeat (2) tick(1, 0, 0, 1, 24'h000000);
        repeat (5) tick(0, 0, 0, 1, 24'hA5C3E7);
        chk("black_p0", hist[3], {3'b001, 16'h8010});
        chk("black_p1", hist[4], {3'b001, 16'h8010});
        chk("blank_0", hist[5], {3'b000, 16'h8010});
        chk("blank_1", hist[6], {3'b000, 16'h8010});
        // Switch to YCbCr bypass at a vsync rise; odd-length line.
        repeat (2) tick(0, 0, 1, 0, 24'h000000);
        repeat (2) tick(0, 0, 0, 0, 24'h000000);
        hist.delete();
        tick(1, 0, 0, 0, 24'h054020);
        tick(1, 0, 0, 0, 24'h226031);
        tick(1, 0, 0, 0, 24'h339055);
        repeat (4) tick(0, 0, 0, 0, 24'h000000);
        chk("byp_p0", hist[3], {3'b001, 16'h5005});
        chk("byp_p1", hist[4], {3'b001, 16'h2922});
        chk("byp_p2", hist[5], {3'b001, 16'h9033});
        chk("byp_end", hist[6], {3'b000, 16'h8010});
        // rgb_in raised mid-frame: still bypass until the next vsync rise.
        hist.delete();
        tick(1, 0, 0, 1, 24'hFFFFFF);
        repeat (4) tick(0, 0, 0, 1, 24'h000000);
        chk("midframe", hist[3], {3'b001, 16'hFFFF});
        tick(0, 0, 1, 1, 24'h000000);
        tick(0, 0, 0, 1, 24'h000000);
        hist.delete();
        tick(1, 0, 0, 1, 24'hFFFFFF);
        repeat (4) tick(0, 0, 0, 1, 24'h000000);
        chk("newframe", hist[3], {3'b001, 16'h80EB});
        // Independent sync delay, including hs/vs edges during de.
        hist.delete();
        for (int i = 0; i < 12; i++) tick(pat[i][0], pat[i][1], pat[i][2], 1, 24'h000000);
        repeat (3) tick(0, 0, 0, 1, 24'h000000);
        for (int i = 0; i < 12; i++) chk($sformatf("sync%0d", i), {16'h0, hist[i+3][18:16]}, {16'h0, pat[i]});
        repeat (2) tick(0, 0, 0, 1, 24'h000000);
        // Reset pulsed mid-line.
        hist.delete();
        repeat (2) tick(1, 0, 0, 1, 24'hFF0000);
        sys2_rst = 1'b1;
        tick(1, 0, 0, 1, 24'hFF0000);
        chk("rst_mid", hist[2], {3'b000, 16'h8010});
        sys2_rst = 1'b0;
        repeat (4) tick(1, 0, 0, 1, 24'hFF0000);
        repeat (4) tick(0, 0, 0, 1, 24'h000000);
        chk("no_stale0", hist[3], {3'b000, 16'h8010});
        chk("no_stale1", hist[4], {3'b000, 16'h8010});
        chk("no_stale2", hist[5], {3'b000, 16'h8010});
        chk("post_p0", hist[6], {3'b001, 16'h663F});
        chk("post_p1", hist[7], {3'b001, 16'hF03F});
        chk("post_p2", hist[8], {3'b001, 16'h663F});
        chk("post_p3", hist[9], {3'b001, 16'hF03F});
        chk("post_end", hist[10], {3'b000, 16'h8010});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
